// File: rtl/sram_port_ctrl_if.sv
// Request/response handshake between the sram_test pattern generator (master)
// and the SRAM port controller (slave).
`timescale 1ns/1ps
interface sram_port_ctrl_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [1:0]        req_be;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, busy
   );
endinterface

// File: rtl/sram_port_ctrl.sv
// Cycle-timed controller for a 256K x 16 asynchronous SRAM: turns single-word
// requests into setup/strobe/hold bus cycles with a dead cycle after reads.
`timescale 1ns/1ps
module sram_port_ctrl #(
   parameter int ADDR_W    = 18,
   parameter int DATA_W    = 16,
   parameter int WR_CYCLES = 2,
   parameter int RD_CYCLES = 3
) (
   input  logic              CLK_48MHZ,
   input  logic              RESET_IN_L8,
   sram_port_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] SRAM_A,
   output logic [3:0]        SRAM_SRBS,
   output logic              SRAM_CE,
   output logic              SRAM_WE,
   output logic              SRAM_OE,
   inout  wire  [DATA_W-1:0] SRAM_D
);
   localparam int MAX_C = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
   localparam int CNT_W = $clog2(MAX_C + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WR_SETUP  = 3'd1,
      ST_WR_PULSE  = 3'd2,
      ST_WR_HOLD   = 3'd3,
      ST_RD_ACCESS = 3'd4,
      ST_RD_DONE   = 3'd5
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] d_out_r;
   logic              d_oe_r;
   logic [3:0]        srbs_r;
   logic              ce_r;
   logic              we_r;
   logic              oe_r;
   logic              req_ready_r;
   logic              busy_r;
   logic              rsp_valid_r;
   logic [DATA_W-1:0] rsp_rdata_r;

   assign SRAM_A        = addr_r;
   assign SRAM_SRBS     = srbs_r;
   assign SRAM_CE       = ce_r;
   assign SRAM_WE       = we_r;
   assign SRAM_OE       = oe_r;
   assign SRAM_D        = d_oe_r ? d_out_r : {DATA_W{1'bz}};
   assign bus.req_ready = req_ready_r;
   assign bus.busy      = busy_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;

   // Bus-cycle sequencer; every SRAM pin and handshake output is a register here.
   always_ff @(posedge CLK_48MHZ or negedge RESET_IN_L8) begin
      if (!RESET_IN_L8) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         addr_r      <= '0;
         d_out_r     <= '0;
         d_oe_r      <= 1'b0;
         srbs_r      <= 4'hF;
         ce_r        <= 1'b1;
         we_r        <= 1'b1;
         oe_r        <= 1'b1;
         req_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               rsp_valid_r <= 1'b0;
               if (bus.req_valid && req_ready_r) begin
                  addr_r      <= bus.req_addr;
                  ce_r        <= 1'b0;
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  if (bus.req_we) begin
                     d_out_r <= bus.req_wdata;
                     d_oe_r  <= 1'b1;
                     srbs_r  <= {2'b11, ~bus.req_be};
                     cnt_r   <= CNT_W'(WR_CYCLES - 1);
                     state_r <= ST_WR_SETUP;
                  end else begin
                     // Reads always fetch both bytes; be only qualifies writes.
                     oe_r    <= 1'b0;
                     srbs_r  <= 4'b1100;
                     cnt_r   <= CNT_W'(RD_CYCLES - 1);
                     state_r <= ST_RD_ACCESS;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WR_SETUP: begin
               we_r    <= 1'b0;
               state_r <= ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
               if (cnt_r == '0) begin
                  we_r        <= 1'b1;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_WR_HOLD;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_WR_HOLD: begin
               ce_r        <= 1'b1;
               srbs_r      <= 4'hF;
               d_oe_r      <= 1'b0;
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
            ST_RD_ACCESS: begin
               if (cnt_r == '0) begin
                  // OE releases at this edge, so the sample sees the SRAM still driving.
                  rsp_rdata_r <= SRAM_D;
                  ce_r        <= 1'b1;
                  oe_r        <= 1'b1;
                  srbs_r      <= 4'hF;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_RD_DONE;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ST_RD_DONE: begin
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
            default: begin
               d_oe_r      <= 1'b0;
               srbs_r      <= 4'hF;
               ce_r        <= 1'b1;
               we_r        <= 1'b1;
               oe_r        <= 1'b1;
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed self-checking bench for sram_port_ctrl with a behavioural async SRAM
// model; a probe driver pulls the data bus to zero to observe DUT release.
`timescale 1ns/1ps
module tb_sram_port_ctrl;
   logic        clk;
   logic        rst_n;
   logic        probe_en;
   logic [17:0] sram_a;
   logic [3:0]  sram_srbs;
   logic        sram_ce;
   logic        sram_we;
   logic        sram_oe;
   wire  [15:0] sram_d;
   logic [15:0] mem [0:262143];
   logic        model_en;
   logic [15:0] model_val;
   int          checks;
   int          failures;

   sram_port_ctrl_if #(.ADDR_W(18), .DATA_W(16)) bus ();

   sram_port_ctrl #(.ADDR_W(18), .DATA_W(16), .WR_CYCLES(2), .RD_CYCLES(3)) dut (
      .CLK_48MHZ   (clk),
      .RESET_IN_L8 (rst_n),
      .bus         (bus.slave),
      .SRAM_A      (sram_a),
      .SRAM_SRBS   (sram_srbs),
      .SRAM_CE     (sram_ce),
      .SRAM_WE     (sram_we),
      .SRAM_OE     (sram_oe),
      .SRAM_D      (sram_d)
   );

   always #10 clk = ~clk;

   assign model_en  = probe_en | (!sram_ce && !sram_oe && sram_we);
   assign model_val = probe_en ? 16'h0000 : mem[sram_a];
   assign sram_d    = model_en ? model_val : 16'hzzzz;

   // SRAM array write: bytes latch while CE and WE are both low.
   always @(negedge clk) begin
      if (rst_n && !sram_ce && !sram_we) begin
         if (!sram_srbs[0]) mem[sram_a][7:0]  <= sram_d[7:0];
         if (!sram_srbs[1]) mem[sram_a][15:8] <= sram_d[15:8];
      end
   end

   task automatic do_write(input logic [17:0] a, input logic [15:0] dat, input logic [1:0] be, input string name);
      logic [4:0] we_v, ce_v, oe_v, rsp_v, rdy_v, d_ok, sb_ok, a_ok;
      logic [3:0] exp_sb;
      exp_sb = {2'b11, ~be};
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = dat; bus.req_be = be;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) bus.req_valid = 1'b0;
         we_v[k-1] = sram_we; ce_v[k-1] = sram_ce; oe_v[k-1] = sram_oe;
         rsp_v[k-1] = bus.rsp_valid; rdy_v[k-1] = bus.req_ready;
         d_ok[k-1] = (sram_d === dat); sb_ok[k-1] = (sram_srbs === exp_sb); a_ok[k-1] = (sram_a === a);
      end
      checks++; if (we_v !== 5'b11001) begin failures++; $display("FAIL %s we_seq got=%b exp=%b", name, we_v, 5'b11001); end
      checks++; if (ce_v !== 5'b10000) begin failures++; $display("FAIL %s ce_seq got=%b exp=%b", name, ce_v, 5'b10000); end
      checks++; if (oe_v !== 5'b11111) begin failures++; $display("FAIL %s oe_seq got=%b exp=%b", name, oe_v, 5'b11111); end
      checks++; if (rsp_v !== 5'b01000) begin failures++; $display("FAIL %s rsp_seq got=%b exp=%b", name, rsp_v, 5'b01000); end
      checks++; if (rdy_v !== 5'b10000) begin failures++; $display("FAIL %s ready_seq got=%b exp=%b", name, rdy_v, 5'b10000); end
      checks++; if (d_ok[3:0] !== 4'hF) begin failures++; $display("FAIL %s d_driven got=%b exp=%b", name, d_ok[3:0], 4'hF); end
      checks++; if (sb_ok[3:0] !== 4'hF) begin failures++; $display("FAIL %s srbs got=%b exp=%b", name, sb_ok[3:0], 4'hF); end
      checks++; if (a_ok !== 5'h1F) begin failures++; $display("FAIL %s addr got=%b exp=%b", name, a_ok, 5'h1F); end
   endtask

   task automatic do_read(input logic [17:0] a, input logic [15:0] exp_d, input logic [1:0] be, input string name);
      logic [4:0] we_v, ce_v, oe_v, rsp_v, rdy_v;
      logic [2:0] sb_ok;
      logic [15:0] rd4, rd5;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.req_wdata = 16'h0000; bus.req_be = be;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) bus.req_valid = 1'b0;
         we_v[k-1] = sram_we; ce_v[k-1] = sram_ce; oe_v[k-1] = sram_oe;
         rsp_v[k-1] = bus.rsp_valid; rdy_v[k-1] = bus.req_ready;
         if (k <= 3) sb_ok[k-1] = (sram_srbs === 4'b1100);
         if (k == 4) rd4 = bus.rsp_rdata;
         if (k == 5) rd5 = bus.rsp_rdata;
      end
      checks++; if (ce_v !== 5'b11000) begin failures++; $display("FAIL %s ce_seq got=%b exp=%b", name, ce_v, 5'b11000); end
      checks++; if (oe_v !== 5'b11000) begin failures++; $display("FAIL %s oe_seq got=%b exp=%b", name, oe_v, 5'b11000); end
      checks++; if (we_v !== 5'b11111) begin failures++; $display("FAIL %s we_seq got=%b exp=%b", name, we_v, 5'b11111); end
      checks++; if (rsp_v !== 5'b01000) begin failures++; $display("FAIL %s rsp_seq got=%b exp=%b", name, rsp_v, 5'b01000); end
      checks++; if (rdy_v !== 5'b10000) begin failures++; $display("FAIL %s ready_seq got=%b exp=%b", name, rdy_v, 5'b10000); end
      checks++; if (sb_ok !== 3'b111) begin failures++; $display("FAIL %s srbs got=%b exp=%b", name, sb_ok, 3'b111); end
      checks++; if (rd4 !== exp_d) begin failures++; $display("FAIL %s rdata got=%h exp=%h", name, rd4, exp_d); end
      checks++; if (rd5 !== exp_d) begin failures++; $display("FAIL %s rdata_hold got=%h exp=%h", name, rd5, exp_d); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; probe_en = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if ({sram_ce, sram_we, sram_oe} !== 3'b111) begin failures++; $display("FAIL reset ce_we_oe got=%b exp=%b", {sram_ce, sram_we, sram_oe}, 3'b111); end
      checks++; if (sram_srbs !== 4'hF) begin failures++; $display("FAIL reset srbs got=%h exp=%h", sram_srbs, 4'hF); end
      checks++; if (sram_d !== 16'h0000) begin failures++; $display("FAIL reset d_release got=%h exp=%h", sram_d, 16'h0000); end
      checks++; if ({bus.req_ready, bus.busy, bus.rsp_valid} !== 3'b100) begin failures++; $display("FAIL reset ready_busy_rsp got=%b exp=%b", {bus.req_ready, bus.busy, bus.rsp_valid}, 3'b100); end
      checks++; if ({sram_a, bus.rsp_rdata} !== 34'h0) begin failures++; $display("FAIL reset addr_rdata got=%h exp=%h", {sram_a, bus.rsp_rdata}, 34'h0); end
      rst_n = 1'b1; probe_en = 1'b0;
   endtask

   task automatic test_write();
      do_write(18'h00005, 16'hA55A, 2'b11, "write_basic");
   endtask

   task automatic test_read();
      do_read(18'h00005, 16'hA55A, 2'b11, "read_basic");
   endtask

   task automatic test_partial_back_to_back();
      do_write(18'h3FFFF, 16'hBEEF, 2'b11, "write_top_full");
      do_write(18'h3FFFF, 16'h1234, 2'b01, "write_top_low");
      do_read(18'h3FFFF, 16'hBE34, 2'b01, "read_top");
   endtask

   task automatic test_be_none();
      do_write(18'h00005, 16'h0000, 2'b00, "write_be00");
      do_read(18'h00005, 16'hA55A, 2'b00, "read_after_be00");
   endtask

   task automatic test_back_to_back();
      logic [10:0] rsp_v, rdy_v, we_v;
      logic a6_ok;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 18'h00005; bus.req_be = 2'b11;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         rsp_v[k-1] = bus.rsp_valid; rdy_v[k-1] = bus.req_ready; we_v[k-1] = sram_we;
         if (k == 6) a6_ok = (sram_a === 18'h00006);
         if (k == 1) begin bus.req_we = 1'b1; bus.req_addr = 18'h00006; bus.req_wdata = 16'h5AA5; end
         if (k == 6) bus.req_valid = 1'b0;
      end
      checks++; if (rdy_v !== 11'b11000010000) begin failures++; $display("FAIL b2b ready_seq got=%b exp=%b", rdy_v, 11'b11000010000); end
      checks++; if (rsp_v !== 11'b00100001000) begin failures++; $display("FAIL b2b rsp_seq got=%b exp=%b", rsp_v, 11'b00100001000); end
      checks++; if (we_v !== 11'b11100111111) begin failures++; $display("FAIL b2b we_seq got=%b exp=%b", we_v, 11'b11100111111); end
      checks++; if (a6_ok !== 1'b1) begin failures++; $display("FAIL b2b addr got=%h exp=%h", sram_a, 18'h00006); end
      checks++; if (mem[6] !== 16'h5AA5) begin failures++; $display("FAIL b2b mem_write got=%h exp=%h", mem[6], 16'h5AA5); end
      checks++; if (bus.rsp_rdata !== 16'hA55A) begin failures++; $display("FAIL b2b rdata_retain got=%h exp=%h", bus.rsp_rdata, 16'hA55A); end
   endtask

   task automatic test_abort();
      int rsp_cnt;
      rsp_cnt = 0;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 18'h00100; bus.req_wdata = 16'hFFFF; bus.req_be = 2'b11;
      @(negedge clk); bus.req_valid = 1'b0;
      @(negedge clk);
      checks++; if (sram_we !== 1'b0) begin failures++; $display("FAIL abort in_pulse we got=%b exp=%b", sram_we, 1'b0); end
      #2 rst_n = 1'b0; probe_en = 1'b1;
      #1;
      checks++; if ({sram_ce, sram_we} !== 2'b11) begin failures++; $display("FAIL abort ce_we got=%b exp=%b", {sram_ce, sram_we}, 2'b11); end
      checks++; if (sram_d !== 16'h0000) begin failures++; $display("FAIL abort d_release got=%h exp=%h", sram_d, 16'h0000); end
      checks++; if (sram_srbs !== 4'hF) begin failures++; $display("FAIL abort srbs got=%h exp=%h", sram_srbs, 4'hF); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1; probe_en = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) rsp_cnt++;
      end
      checks++; if (rsp_cnt !== 0) begin failures++; $display("FAIL abort rsp_count got=%0d exp=%0d", rsp_cnt, 0); end
      checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL abort ready got=%b exp=%b", bus.req_ready, 1'b1); end
      checks++; if ({sram_a, bus.rsp_rdata} !== 34'h0) begin failures++; $display("FAIL abort addr_rdata got=%h exp=%h", {sram_a, bus.rsp_rdata}, 34'h0); end
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; probe_en = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 18'h0; bus.req_wdata = 16'h0; bus.req_be = 2'b00;
      checks = 0; failures = 0;
      test_reset();
      test_write();
      test_read();
      test_partial_back_to_back();
      test_be_none();
      test_back_to_back();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
